// File: rtl/imem_ctrl_pkg.sv
// imem_ctrl_pkg: shared types and constants for the instruction memory controller.
// Revision 1.0
`default_nettype none
package imem_ctrl_pkg;
  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int          MEM_BYTES_DFLT = 512;
  localparam logic [31:0] NOP_WORD       = 32'h0000_0000;
endpackage
`default_nettype wire

// File: rtl/imem_fetch_pipe.sv
// imem_fetch_pipe: fetch range/alignment check and one-cycle response register.
// Revision 1.0
`default_nettype none
module imem_fetch_pipe
  import imem_ctrl_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DFLT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        accept,
  input  logic [31:0] fetch_addr,
  input  logic [31:0] mem_rdata,
  output logic        fetch_valid,
  output logic [31:0] fetch_data,
  output logic        fetch_err
);
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  logic range_err;

  // Full 32-bit compare so aliased high addresses are rejected, not wrapped.
  assign range_err = (fetch_addr[1:0] != 2'b00) || (fetch_addr > LAST_WORD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_valid <= 1'b0;
      fetch_data  <= NOP_WORD;
      fetch_err   <= 1'b0;
    end else begin
      fetch_valid <= accept;
      fetch_err   <= accept && range_err;
      fetch_data  <= (accept && !range_err) ? mem_rdata : NOP_WORD;
    end
  end
endmodule
`default_nettype wire

// File: rtl/imem_ctrl.sv
// imem_ctrl: boot-loads instruction memory from a byte stream, then serves CPU fetches.
// Revision 1.0
`default_nettype none
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DFLT,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              ld_restart,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_run,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_valid,
  output logic [31:0]       fetch_data,
  output logic              fetch_err,
  output logic [ADDR_W:0]   load_count,
  output logic              load_ovf
);
  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(MEM_BYTES - 1);

  state_t          state;
  logic [ADDR_W:0] count;
  logic            in_load;
  logic            accept;
  logic            at_top;

  assign in_load    = (state == LOAD);
  assign at_top     = (count[ADDR_W-1:0] == TOP_ADDR);
  assign ld_ready   = in_load;
  // Write strobe is masked during reset so a byte in flight is never committed.
  assign mem_we     = in_load && ld_valid && reset_n;
  assign mem_wdata  = ld_data;
  assign mem_addr   = in_load ? count[ADDR_W-1:0] : fetch_addr[ADDR_W-1:0];
  assign accept     = (state == RUN) && fetch_req;
  assign load_count = count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= LOAD;
      count    <= '0;
      load_ovf <= 1'b0;
      cpu_run  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (ld_valid) begin
            count <= count + 1'b1;
            if (ld_last || at_top) begin
              state    <= RUN;
              cpu_run  <= 1'b1;
              load_ovf <= !ld_last;
            end
          end
        end
        RUN: begin
          if (ld_restart) begin
            state    <= LOAD;
            cpu_run  <= 1'b0;
            count    <= '0;
            load_ovf <= 1'b0;
          end
        end
        default: begin
          state   <= LOAD;
          cpu_run <= 1'b0;
        end
      endcase
    end
  end

  imem_fetch_pipe #(
    .MEM_BYTES(MEM_BYTES)
  ) u_fetch (
    .clk        (clk),
    .reset_n    (reset_n),
    .accept     (accept),
    .fetch_addr (fetch_addr),
    .mem_rdata  (mem_rdata),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .fetch_err  (fetch_err)
  );
endmodule
`default_nettype wire

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: self-checking bench for imem_ctrl with a behavioural byte memory.
// Revision 1.0
`default_nettype none
module tb_imem_ctrl;
  localparam int MB = 512;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        ld_restart = 1'b0;
  logic [8:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [31:0] mem_rdata;
  logic        cpu_run;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = 32'h0;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_err;
  logic [9:0]  load_count;
  logic        load_ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        exp_err;
  } fvec_t;

  resp_t      exp_q[$];
  logic [7:0] mem     [MB] = '{default: 8'h00};
  logic [7:0] ref_img [MB] = '{default: 8'h00};
  logic [8:0] exp_addr = '0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = {mem[mem_addr], mem[mem_addr + 9'd1], mem[mem_addr + 9'd2], mem[mem_addr + 9'd3]};

  imem_ctrl #(.MEM_BYTES(MB), .ADDR_W(9)) dut (
    .clk(clk), .reset_n(reset_n), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .ld_restart(ld_restart),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_run(cpu_run), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .fetch_err(fetch_err), .load_count(load_count), .load_ovf(load_ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic resp_t model(input logic [31:0] a);
    resp_t r;
    logic [8:0] b;
    b = a[8:0];
    r.err  = (a[1:0] != 2'b00) || (a > 32'd508);
    r.data = r.err ? 32'h0 : {ref_img[b], ref_img[b + 9'd1], ref_img[b + 9'd2], ref_img[b + 9'd3]};
    return r;
  endfunction

  // Leaves ld_valid asserted so consecutive calls stream without bubbles.
  task automatic load_byte(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    #1;
    chk("ld_we", {63'd0, mem_we}, 64'd1);
    chk("ld_addr", {55'd0, mem_addr}, {55'd0, exp_addr});
    chk("ld_ready", {63'd0, ld_ready}, 64'd1);
    ref_img[exp_addr] = d;
    exp_addr = exp_addr + 9'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic exp_accept);
    fetch_req  = 1'b1;
    fetch_addr = a;
    if (exp_accept) exp_q.push_back(model(a));
    tick();
  endtask

  // Response monitor: every valid response must match the oldest outstanding request.
  always @(negedge clk) begin
    if (reset_n && fetch_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got valid=1 expected no response");
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("resp_err", {63'd0, fetch_err}, {63'd0, e.err});
        chk("resp_data", {32'd0, fetch_data}, {32'd0, e.data});
      end
    end
  end

  fvec_t vecs[10];

  initial begin
    vecs[0] = '{32'h0000_0000, 1'b0};
    vecs[1] = '{32'h0000_0004, 1'b0};
    vecs[2] = '{32'h0000_0002, 1'b1};
    vecs[3] = '{32'h0000_01FE, 1'b1};
    vecs[4] = '{32'h0000_0200, 1'b1};
    vecs[5] = '{32'h0000_01FC, 1'b0};
    vecs[6] = '{32'hFFFF_FFFC, 1'b1};
    vecs[7] = '{32'h0000_0001, 1'b1};
    vecs[8] = '{32'h0000_0100, 1'b0};
    vecs[9] = '{32'h0000_0200, 1'b1};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, ld_ready}, 64'd1);
    chk("rst_we", {63'd0, mem_we}, 64'd0);
    chk("rst_run", {63'd0, cpu_run}, 64'd0);
    chk("rst_fvalid", {63'd0, fetch_valid}, 64'd0);
    chk("rst_fdata", {32'd0, fetch_data}, 64'd0);
    chk("rst_ferr", {63'd0, fetch_err}, 64'd0);
    chk("rst_count", {54'd0, load_count}, 64'd0);
    chk("rst_ovf", {63'd0, load_ovf}, 64'd0);
    reset_n = 1'b1;
    tick();

    // Short image, ld_last on the fourth byte
    load_byte(8'h20, 1'b0);
    load_byte(8'h08, 1'b0);
    load_byte(8'h00, 1'b0);
    chk("pre_run", {63'd0, cpu_run}, 64'd0);
    load_byte(8'h20, 1'b1);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("boot_run", {63'd0, cpu_run}, 64'd1);
    chk("boot_count", {54'd0, load_count}, 64'd4);
    chk("boot_ovf", {63'd0, load_ovf}, 64'd0);
    chk("boot_ready", {63'd0, ld_ready}, 64'd0);

    // First fetch is accepted in the first RUN cycle; latency one
    fetch(32'h0, 1'b1);
    fetch_req = 1'b0;
    chk("lat_valid", {63'd0, fetch_valid}, 64'd1);
    chk("lat_data", {32'd0, fetch_data}, 64'h2008_0020);
    chk("lat_err", {63'd0, fetch_err}, 64'd0);
    tick();
    chk("idle_valid", {63'd0, fetch_valid}, 64'd0);

    // Back-to-back fetch vectors
    for (int i = 0; i < 10; i++) begin
      chk("vec_model_err", {63'd0, model(vecs[i].addr).err}, {63'd0, vecs[i].exp_err});
      fetch(vecs[i].addr, 1'b1);
    end
    fetch_req = 1'b0;
    tick();
    tick();

    // Restart together with a fetch: fetch still answered
    ld_restart = 1'b1;
    fetch(32'h8, 1'b1);
    ld_restart = 1'b0;
    chk("rs_valid", {63'd0, fetch_valid}, 64'd1);
    chk("rs_run", {63'd0, cpu_run}, 64'd0);
    chk("rs_ready", {63'd0, ld_ready}, 64'd1);
    chk("rs_count", {54'd0, load_count}, 64'd0);
    chk("rs_ovf", {63'd0, load_ovf}, 64'd0);
    fetch(32'h0, 1'b0);
    fetch_req = 1'b0;
    chk("load_nofetch", {63'd0, fetch_valid}, 64'd0);
    exp_addr = '0;

    // Full image without ld_last -> overflow
    for (int i = 0; i < MB; i++) load_byte(8'($urandom), 1'b0);
    chk("ovf_run", {63'd0, cpu_run}, 64'd1);
    chk("ovf_flag", {63'd0, load_ovf}, 64'd1);
    chk("ovf_count", {54'd0, load_count}, 64'd512);
    ld_data = 8'hEE;
    #1;
    chk("ovf_ignore_we", {63'd0, mem_we}, 64'd0);
    tick();
    ld_valid = 1'b0;
    chk("ovf_hold_count", {54'd0, load_count}, 64'd512);
    fetch(32'h1FC, 1'b1);
    fetch(32'h0, 1'b1);
    for (int i = 0; i < 6; i++) fetch({23'd0, 9'($urandom_range(0, 127) * 4)}, 1'b1);
    fetch_req = 1'b0;
    tick();

    // Reset mid-stream at byte 5
    ld_restart = 1'b1;
    tick();
    ld_restart = 1'b0;
    exp_addr = '0;
    for (int i = 0; i < 5; i++) load_byte(8'hA0 + 8'(i), 1'b0);
    ld_data = 8'h55;
    reset_n = 1'b0;
    #1;
    chk("mr_we", {63'd0, mem_we}, 64'd0);
    chk("mr_count", {54'd0, load_count}, 64'd0);
    chk("mr_run", {63'd0, cpu_run}, 64'd0);
    chk("mr_ready", {63'd0, ld_ready}, 64'd1);
    chk("mr_addr", {55'd0, mem_addr}, 64'd0);
    ld_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    exp_addr = '0;
    load_byte(8'h3C, 1'b0);
    load_byte(8'h01, 1'b0);
    load_byte(8'h12, 1'b0);
    load_byte(8'h34, 1'b1);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("rl_count", {54'd0, load_count}, 64'd4);
    chk("rl_run", {63'd0, cpu_run}, 64'd1);
    fetch(32'h0, 1'b1);
    fetch(32'h4, 1'b1);
    fetch_req = 1'b0;
    tick();
    tick();
    chk("q_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
